// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU op codes, forward-select encoding and default widths.
package cpu_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    FWD_RF,
    FWD_EXMEM,
    FWD_MEMWB
  } fwd_sel_e;

endpackage

// File: rtl/fwd_mux.sv
// Combinational operand forwarding select: EX/MEM beats MEM/WB, register 0 is never forwarded.
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic [REG_AW-1:0] src_addr_i,
  input  logic [DATA_W-1:0] rf_data_i,
  input  logic              exmem_reg_write_i,
  input  logic [REG_AW-1:0] exmem_rd_addr_i,
  input  logic [DATA_W-1:0] exmem_result_i,
  input  logic              memwb_reg_write_i,
  input  logic [REG_AW-1:0] memwb_rd_addr_i,
  input  logic [DATA_W-1:0] memwb_result_i,
  output logic [DATA_W-1:0] fwd_data_o
);

  fwd_sel_e sel;

  always_comb begin
    // NOTE: every combinational output is given a default first so no path infers a latch.
    sel = FWD_RF;
    if (exmem_reg_write_i && (exmem_rd_addr_i != '0) && (exmem_rd_addr_i == src_addr_i)) begin
      sel = FWD_EXMEM;
    end else if (memwb_reg_write_i && (memwb_rd_addr_i != '0) && (memwb_rd_addr_i == src_addr_i)) begin
      sel = FWD_MEMWB;
    end
  end

  always_comb begin
    unique case (sel)
      FWD_EXMEM: fwd_data_o = exmem_result_i;
      FWD_MEMWB: fwd_data_o = memwb_result_i;
      default:   fwd_data_o = rf_data_i;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, valid/ready handshake,
// flush, and forwarded ALU operand selection.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic [3:0]        id_alu_ctrl,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd_addr,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd_addr,
  input  logic [DATA_W-1:0] memwb_result,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [DATA_W-1:0] alu_data1,
  output logic [DATA_W-1:0] alu_data2,
  output logic [3:0]        alu_ctrl,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
  logic [REG_AW-1:0] rs_addr_q, rs_addr_d, rt_addr_q, rt_addr_d, rd_addr_q, rd_addr_d;
  logic [3:0]        alu_ctrl_q, alu_ctrl_d;
  logic              alu_src_q, alu_src_d;
  logic              reg_write_q, reg_write_d, mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d, mem_to_reg_q, mem_to_reg_d;

  logic              hazard, advance, load;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;

  // Conservative: a load in EX stalls any ID consumer of its rd, immediate or not.
  assign hazard   = valid_q & mem_read_q & (rd_addr_q != '0) &
                    ((rd_addr_q == id_rs_addr) | (rd_addr_q == id_rt_addr));
  assign advance  = ex_ready | ~valid_q;
  assign in_ready = advance & ~hazard;
  assign load     = in_valid & in_ready;

  always_comb begin
    valid_d      = valid_q;
    rs_data_d    = rs_data_q;
    rt_data_d    = rt_data_q;
    imm_d        = imm_q;
    rs_addr_d    = rs_addr_q;
    rt_addr_d    = rt_addr_q;
    rd_addr_d    = rd_addr_q;
    alu_ctrl_d   = alu_ctrl_q;
    alu_src_d    = alu_src_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_to_reg_d = mem_to_reg_q;
    if (flush || (advance && !load)) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end else if (advance) begin
      valid_d      = 1'b1;
      rs_data_d    = id_rs_data;
      rt_data_d    = id_rt_data;
      imm_d        = id_imm;
      rs_addr_d    = id_rs_addr;
      rt_addr_d    = id_rt_addr;
      rd_addr_d    = id_rd_addr;
      alu_ctrl_d   = id_alu_ctrl;
      alu_src_d    = id_alu_src;
      reg_write_d  = id_reg_write;
      mem_read_d   = id_mem_read;
      mem_write_d  = id_mem_write;
      mem_to_reg_d = id_mem_to_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      valid_q      <= 1'b0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      rs_addr_q    <= '0;
      rt_addr_q    <= '0;
      rd_addr_q    <= '0;
      alu_ctrl_q   <= '0;
      alu_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      rs_data_q    <= rs_data_d;
      rt_data_q    <= rt_data_d;
      imm_q        <= imm_d;
      rs_addr_q    <= rs_addr_d;
      rt_addr_q    <= rt_addr_d;
      rd_addr_q    <= rd_addr_d;
      alu_ctrl_q   <= alu_ctrl_d;
      alu_src_q    <= alu_src_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
    end
  end

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .src_addr_i        (rs_addr_q),
    .rf_data_i         (rs_data_q),
    .exmem_reg_write_i (exmem_reg_write),
    .exmem_rd_addr_i   (exmem_rd_addr),
    .exmem_result_i    (exmem_result),
    .memwb_reg_write_i (memwb_reg_write),
    .memwb_rd_addr_i   (memwb_rd_addr),
    .memwb_result_i    (memwb_result),
    .fwd_data_o        (fwd_rs)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .src_addr_i        (rt_addr_q),
    .rf_data_i         (rt_data_q),
    .exmem_reg_write_i (exmem_reg_write),
    .exmem_rd_addr_i   (exmem_rd_addr),
    .exmem_result_i    (exmem_result),
    .memwb_reg_write_i (memwb_reg_write),
    .memwb_rd_addr_i   (memwb_rd_addr),
    .memwb_result_i    (memwb_result),
    .fwd_data_o        (fwd_rt)
  );

  assign ex_valid      = valid_q;
  assign alu_data1     = fwd_rs;
  assign alu_data2     = alu_src_q ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign alu_ctrl      = alu_ctrl_q;
  assign ex_rd_addr    = rd_addr_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_mem_to_reg = mem_to_reg_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vectors, corner sequences, randomized model compare.
module tb_id_ex_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic [3:0]  id_alu_ctrl;
  logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd_addr, memwb_rd_addr;
  logic [31:0] exmem_result, memwb_result;
  logic        ex_ready, ex_valid;
  logic [31:0] alu_data1, alu_data2, ex_store_data;
  logic [3:0]  alu_ctrl;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_alu_ctrl(id_alu_ctrl), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .exmem_reg_write(exmem_reg_write), .exmem_rd_addr(exmem_rd_addr), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd_addr(memwb_rd_addr), .memwb_result(memwb_result),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .alu_data1(alu_data1), .alu_data2(alu_data2),
    .alu_ctrl(alu_ctrl), .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg)
  );

  typedef struct {
    logic [4:0]  rs_addr, rt_addr;
    logic [31:0] rs_data, rt_data, imm;
    logic [3:0]  ctrl;
    logic        alu_src;
    logic        exw;
    logic [4:0]  exrd;
    logic [31:0] exres;
    logic        mww;
    logic [4:0]  mwrd;
    logic [31:0] mwres;
    logic [31:0] exp_d1, exp_d2, exp_st;
  } vec_t;

  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd, imm;
    logic [3:0]  ctrl;
    logic        src, rw, mr, mw, m2r;
  } instr_t;

  vec_t   vecs[6];
  instr_t pipe[$];
  logic [3:0] ops[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_fwd(input logic exw, input logic [4:0] exrd, input logic [31:0] exres,
                         input logic mww, input logic [4:0] mwrd, input logic [31:0] mwres);
    exmem_reg_write = exw; exmem_rd_addr = exrd; exmem_result = exres;
    memwb_reg_write = mww; memwb_rd_addr = mwrd; memwb_result = mwres;
  endtask

  task automatic offer(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                       input logic [3:0] ctrl, input logic src, input logic rw, input logic mr,
                       input logic mw, input logic m2r);
    id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_alu_ctrl = ctrl; id_alu_src = src; id_reg_write = rw;
    id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
    in_valid = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference forwarding: newest producer wins, $0 always reads the register file.
  function automatic logic [31:0] ref_fwd(input logic [4:0] a, input logic [31:0] rf);
    if (a == 5'd0) return rf;
    if (exmem_reg_write && exmem_rd_addr == a) return exmem_result;
    if (memwb_reg_write && memwb_rd_addr == a) return memwb_result;
    return rf;
  endfunction

  function automatic instr_t cur_id();
    instr_t t;
    t.rs = id_rs_addr; t.rt = id_rt_addr; t.rd = id_rd_addr;
    t.rsd = id_rs_data; t.rtd = id_rt_data; t.imm = id_imm;
    t.ctrl = id_alu_ctrl; t.src = id_alu_src; t.rw = id_reg_write;
    t.mr = id_mem_read; t.mw = id_mem_write; t.m2r = id_mem_to_reg;
    return t;
  endfunction

  initial begin
    instr_t cur;
    logic   exp_ready, occupied, do_flush;
    logic [31:0] exp_rt;

    vecs[0] = '{5'd1, 5'd2, 32'd5, 32'd3, 32'd0, ALU_ADD, 1'b0,
                1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd5, 32'd3, 32'd3};
    vecs[1] = '{5'd3, 5'd5, 32'h11, 32'd7, 32'd0, ALU_SUB, 1'b0,
                1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd3, 32'hBBBB, 32'hAAAA, 32'd7, 32'd7};
    vecs[2] = '{5'd0, 5'd0, 32'h77, 32'h66, 32'd0, ALU_OR, 1'b0,
                1'b1, 5'd0, 32'hAAAA, 1'b1, 5'd0, 32'hBBBB, 32'h77, 32'h66, 32'h66};
    vecs[3] = '{5'd1, 5'd6, 32'd1, 32'd9, 32'd0, ALU_AND, 1'b0,
                1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'hCCCC, 32'd1, 32'hCCCC, 32'hCCCC};
    vecs[4] = '{5'd7, 5'd7, 32'd2, 32'd3, 32'hFFFF_FFF0, ALU_SLT, 1'b1,
                1'b1, 5'd7, 32'h1234, 1'b0, 5'd0, 32'd0, 32'h1234, 32'hFFFF_FFF0, 32'h1234};
    vecs[5] = '{5'd2, 5'd9, 32'd4, 32'd5, 32'd0, ALU_NOR, 1'b0,
                1'b0, 5'd2, 32'hDEAD, 1'b1, 5'd2, 32'hBEEF, 32'hBEEF, 32'd5, 32'd5};
    ops = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR};

    rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
    offer(5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check("reset_ex_valid", 32'(ex_valid), 32'd0);
    check("reset_alu_ctrl", 32'(alu_ctrl), 32'd0);
    check("reset_alu_data1", alu_data1, 32'd0);
    rst = 1'b0;

    // Reset asserted asynchronously while an instruction is in flight.
    offer(5'd1, 5'd2, 5'd8, 32'h1234, 32'd0, 32'd0, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_ex_valid", 32'(ex_valid), 32'd0);
    check("async_rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    check("async_rst_reg_write", 32'(ex_reg_write), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("post_rst_in_ready", 32'(in_ready), 32'd1);
    next_cycle();
    in_valid = 1'b0;
    #1;
    check("post_rst_ex_valid", 32'(ex_valid), 32'd1);
    check("post_rst_alu_data1", alu_data1, 32'h1234);
    check("post_rst_alu_ctrl", 32'(alu_ctrl), 32'(ALU_ADD));

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      offer(vecs[i].rs_addr, vecs[i].rt_addr, 5'd20, vecs[i].rs_data, vecs[i].rt_data,
            vecs[i].imm, vecs[i].ctrl, vecs[i].alu_src, 1'b1, 1'b0, 1'b0, 1'b0);
      next_cycle();
      in_valid = 1'b0;
      set_fwd(vecs[i].exw, vecs[i].exrd, vecs[i].exres, vecs[i].mww, vecs[i].mwrd, vecs[i].mwres);
      #1;
      check($sformatf("vec%0d_ex_valid", i), 32'(ex_valid), 32'd1);
      check($sformatf("vec%0d_alu_data1", i), alu_data1, vecs[i].exp_d1);
      check($sformatf("vec%0d_alu_data2", i), alu_data2, vecs[i].exp_d2);
      check($sformatf("vec%0d_store_data", i), ex_store_data, vecs[i].exp_st);
      check($sformatf("vec%0d_alu_ctrl", i), 32'(alu_ctrl), 32'(vecs[i].ctrl));
    end

    // Load-use: lw $4 in EX, add reading $4 offered from ID.
    @(negedge clk);
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    offer(5'd1, 5'd2, 5'd4, 32'd100, 32'd0, 32'd8, ALU_ADD, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    next_cycle();
    offer(5'd4, 5'd2, 5'd10, 32'd1, 32'd2, 32'd0, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("lu_in_ready_stall", 32'(in_ready), 32'd0);
    check("lu_load_in_ex", 32'(ex_mem_read), 32'd1);
    next_cycle();
    #1;
    check("lu_bubble_valid", 32'(ex_valid), 32'd0);
    check("lu_bubble_reg_write", 32'(ex_reg_write), 32'd0);
    check("lu_in_ready_after", 32'(in_ready), 32'd1);
    next_cycle();
    in_valid = 1'b0;
    #1;
    check("lu_accept_valid", 32'(ex_valid), 32'd1);
    check("lu_accept_rd", 32'(ex_rd_addr), 32'd10);
    check("lu_accept_mem_read", 32'(ex_mem_read), 32'd0);

    // Backpressure: three held cycles, then the waiting instruction loads.
    @(negedge clk);
    offer(5'd1, 5'd2, 5'd11, 32'h55, 32'd0, 32'd0, ALU_OR, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    next_cycle();
    ex_ready = 1'b0;
    offer(5'd3, 5'd2, 5'd12, 32'h66, 32'd0, 32'd0, ALU_SUB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
      check($sformatf("bp%0d_ex_valid", i), 32'(ex_valid), 32'd1);
      check($sformatf("bp%0d_rd", i), 32'(ex_rd_addr), 32'd11);
      check($sformatf("bp%0d_alu_data1", i), alu_data1, 32'h55);
      check($sformatf("bp%0d_alu_ctrl", i), 32'(alu_ctrl), 32'(ALU_OR));
      next_cycle();
    end
    ex_ready = 1'b1;
    #1 check("bp_release_in_ready", 32'(in_ready), 32'd1);
    next_cycle();
    in_valid = 1'b0;
    #1;
    check("bp_next_rd", 32'(ex_rd_addr), 32'd12);
    check("bp_next_alu_data1", alu_data1, 32'h66);

    // Flush coinciding with an accepted-looking offer drops it.
    @(negedge clk);
    offer(5'd1, 5'd2, 5'd13, 32'h99, 32'd0, 32'd0, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    #1 check("flush_in_ready", 32'(in_ready), 32'd1);
    next_cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    #1 check("flush_ex_valid", 32'(ex_valid), 32'd0);
    next_cycle();
    #1 check("flush_not_resurrected", 32'(ex_valid), 32'd0);

    // Randomized run against a queue-based occupancy model (stage holds 0 or 1 instruction).
    pipe.delete();
    @(negedge clk);
    for (int c = 0; c < 400; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      ex_ready = ($urandom_range(0, 3) != 0);
      do_flush = ($urandom_range(0, 15) == 0);
      flush = do_flush;
      offer(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom, $urandom, $urandom, ops[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      in_valid = 1'($urandom_range(0, 1));
      set_fwd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      #1;
      occupied = (pipe.size() != 0);
      exp_ready = ex_ready || !occupied;
      if (occupied && pipe[0].mr && pipe[0].rd != 5'd0 &&
          (pipe[0].rd == id_rs_addr || pipe[0].rd == id_rt_addr))
        exp_ready = 1'b0;
      check("rnd_in_ready", 32'(in_ready), 32'(exp_ready));
      check("rnd_ex_valid", 32'(ex_valid), 32'(occupied));
      if (occupied) begin
        cur = pipe[0];
        exp_rt = ref_fwd(cur.rt, cur.rtd);
        check("rnd_alu_data1", alu_data1, ref_fwd(cur.rs, cur.rsd));
        check("rnd_alu_data2", alu_data2, cur.src ? cur.imm : exp_rt);
        check("rnd_store_data", ex_store_data, exp_rt);
        check("rnd_alu_ctrl", 32'(alu_ctrl), 32'(cur.ctrl));
        check("rnd_rd", 32'(ex_rd_addr), 32'(cur.rd));
        check("rnd_ctrl_bits", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}),
              32'({cur.rw, cur.mr, cur.mw, cur.m2r}));
      end else begin
        check("rnd_idle_writes", 32'({ex_reg_write, ex_mem_read, ex_mem_write}), 32'd0);
      end
      cur = cur_id();
      if (do_flush) begin
        pipe.delete();
      end else if (ex_ready || !occupied) begin
        pipe.delete();
        if (in_valid && exp_ready) pipe.push_back(cur);
      end
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
